// File: rtl/ribbon_scan_sequencer.sv
// Round-robin ribbon ADC scan sequencer.
// Settles the mux, handshakes one conversion, and keeps a windowed peak per channel.
module ribbon_scan_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int WINDOW_SAMPLES = 64,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT        = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_mask,
    output logic [$clog2(NUM_CH)-1:0] mux_sel,
    output logic                      conv_req,
    input  logic                      conv_done,
    input  logic [7:0]                conv_data,
    output logic [NUM_CH*8-1:0]       r_val_s,
    output logic [NUM_CH-1:0]         r_valid,
    output logic                      err_timeout,
    output logic                      busy
);

    localparam int SW  = $clog2(NUM_CH);
    localparam int CW  = $clog2(WINDOW_SAMPLES);
    localparam int STW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, REQ, UPDATE} state_t;

    state_t                       state_q, state_d;
    logic [SW-1:0]                mux_sel_q, mux_sel_d;
    logic [SW-1:0]                last_q, last_d;
    logic [STW-1:0]               set_cnt_q, set_cnt_d;
    logic [TW-1:0]                to_cnt_q, to_cnt_d;
    logic                         conv_req_q, conv_req_d;
    logic                         busy_q, busy_d;
    logic                         err_q, err_d;
    logic [NUM_CH-1:0]            r_valid_q, r_valid_d;
    logic [NUM_CH-1:0][7:0]       r_val_q, r_val_d;
    logic [NUM_CH-1:0][7:0]       r_max_q, r_max_d;
    logic [NUM_CH-1:0][CW-1:0]    count_q, count_d;

    logic [SW-1:0] nxt;
    logic [7:0]    upd_max;
    logic          go_on;
    logic          decide;

    // Lowest set mask bit strictly after `from`, wrapping through 0.
    function automatic logic [SW-1:0] next_ch(input logic [SW-1:0] from,
                                              input logic [NUM_CH-1:0] mask);
        logic [SW-1:0] pick;
        logic [SW-1:0] idx;
        logic          found;
        pick  = from;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = SW'((int'(from) + i) % NUM_CH);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign go_on   = enable && (|ch_mask);
    assign nxt     = next_ch(last_q, ch_mask);
    assign upd_max = (conv_data > r_max_q[mux_sel_q]) ? conv_data
                                                       : r_max_q[mux_sel_q];

    always_comb begin
        state_d    = state_q;
        mux_sel_d  = mux_sel_q;
        last_d     = last_q;
        set_cnt_d  = set_cnt_q;
        to_cnt_d   = to_cnt_q;
        conv_req_d = conv_req_q;
        err_d      = 1'b0;
        r_valid_d  = '0;
        r_val_d    = r_val_q;
        r_max_d    = r_max_q;
        count_d    = count_q;
        decide     = 1'b0;
        unique case (state_q)
            IDLE: decide = 1'b1;
            SETTLE: begin
                if (set_cnt_q == STW'(SETTLE_CYCLES - 1)) begin
                    state_d    = REQ;
                    conv_req_d = 1'b1;
                    to_cnt_d   = TW'(1);
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            REQ: begin
                if (to_cnt_q == TW'(TIMEOUT)) begin
                    decide = 1'b1;
                end else if (conv_done) begin
                    conv_req_d = 1'b0;
                    state_d    = UPDATE;
                    if (count_q[mux_sel_q] == CW'(WINDOW_SAMPLES - 1)) begin
                        r_val_d[mux_sel_q]   = upd_max;
                        r_max_d[mux_sel_q]   = '0;
                        count_d[mux_sel_q]   = '0;
                        r_valid_d[mux_sel_q] = 1'b1;
                    end else begin
                        r_max_d[mux_sel_q] = upd_max;
                        count_d[mux_sel_q] = count_q[mux_sel_q] + 1'b1;
                    end
                end else begin
                    // Last REQ cycle is spent with the request dropped.
                    if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        err_d      = 1'b1;
                        conv_req_d = 1'b0;
                    end
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            UPDATE: decide = 1'b1;
        endcase
        if (decide) begin
            if (go_on) begin
                state_d   = SETTLE;
                mux_sel_d = nxt;
                last_d    = nxt;
                set_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mux_sel_q  <= '0;
            last_q     <= SW'(NUM_CH - 1);
            set_cnt_q  <= '0;
            to_cnt_q   <= '0;
            conv_req_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            r_valid_q  <= '0;
            r_val_q    <= '0;
            r_max_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mux_sel_q  <= mux_sel_d;
            last_q     <= last_d;
            set_cnt_q  <= set_cnt_d;
            to_cnt_q   <= to_cnt_d;
            conv_req_q <= conv_req_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            r_valid_q  <= r_valid_d;
            r_val_q    <= r_val_d;
            r_max_q    <= r_max_d;
            count_q    <= count_d;
        end
    end

    assign mux_sel     = mux_sel_q;
    assign conv_req    = conv_req_q;
    assign r_val_s     = r_val_q;
    assign r_valid     = r_valid_q;
    assign err_timeout = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ribbon_scan_sequencer.sv
// Directed bench for ribbon_scan_sequencer: a step table plus a few
// hand-written reset and idle sequences.
module tb_ribbon_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  ch_mask = 4'b0000;
    logic [1:0]  mux_sel;
    logic        conv_req;
    logic        conv_done = 1'b0;
    logic [7:0]  conv_data = 8'h00;
    logic [31:0] r_val_s;
    logic [3:0]  r_valid;
    logic        err_timeout;
    logic        busy;

    ribbon_scan_sequencer #(
        .NUM_CH(4),
        .WINDOW_SAMPLES(4),
        .SETTLE_CYCLES(16),
        .TIMEOUT(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ch_mask(ch_mask),
        .mux_sel(mux_sel),
        .conv_req(conv_req),
        .conv_done(conv_done),
        .conv_data(conv_data),
        .r_val_s(r_val_s),
        .r_valid(r_valid),
        .err_timeout(err_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         start;
        bit         en;
        bit         to;
        logic [3:0] mask;
        logic [7:0] d;
        int         ch;
        logic [3:0] vld;
        logic [7:0] val;
    } vec_t;

    vec_t       tbl[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_rv [4];

    logic [1:0] mon_mux = 2'd0;
    logic       mon_req = 1'b0;
    int         mon_since = 0;
    int         mon_low = 0;
    int         last_since = 0;
    int         last_low = 0;

    always @(posedge clk) begin
        if (!rst) begin
            mon_mux   <= 2'd0;
            mon_req   <= 1'b0;
            mon_since <= 0;
            mon_low   <= 0;
        end else begin
            mon_mux   <= mux_sel;
            mon_req   <= conv_req;
            mon_since <= (mux_sel != mon_mux) ? 0 : mon_since + 1;
            mon_low   <= conv_req ? 0 : mon_low + 1;
            if (conv_req && !mon_req) begin
                last_since <= (mux_sel != mon_mux) ? 0 : mon_since + 1;
                last_low   <= mon_low;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_rv();
        return {exp_rv[3], exp_rv[2], exp_rv[1], exp_rv[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (conv_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic [3:0] mask, input bit en);
        bit ok;
        if (enable) begin
            wait_req(ok);
            if (!ok) chk("rst_req_wait", 32'd0, 32'd1);
        end
        #2;
        rst = 1'b0;
        enable = 1'b0;
        ch_mask = mask;
        #1;
        chk("rst_conv_req", {31'd0, conv_req}, 32'd0);
        chk("rst_r_val_s", r_val_s, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_r_valid", {28'd0, r_valid}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_mux_sel", {30'd0, mux_sel}, 32'd0);
        for (int k = 0; k < 4; k++) exp_rv[k] = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        enable = en;
    endtask

    function automatic void add(input bit start, input bit en, input bit to,
                                input logic [3:0] mask, input logic [7:0] d,
                                input int ch, input logic [3:0] vld,
                                input logic [7:0] val);
        vec_t v;
        v.start = start; v.en = en; v.to = to; v.mask = mask;
        v.d = d; v.ch = ch; v.vld = vld; v.val = val;
        tbl.push_back(v);
    endfunction

    vec_t v;
    int   prev_ch;
    bit   first;
    bit   ok;
    bit   abort;
    int   k;

    initial begin
        // round-robin over all four channels
        add(1, 1, 0, 4'b1111, 8'd5, 0, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1111, 8'd6, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1111, 8'd7, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1111, 8'd8, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1111, 8'd9, 0, 4'b0000, 8'd0);
        // two peak-hold windows on channel 2
        add(1, 1, 0, 4'b0100, 8'd10, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0100, 8'd200, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0100, 8'd50, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0100, 8'd7, 2, 4'b0100, 8'd200);
        add(0, 1, 0, 4'b0100, 8'd1, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0100, 8'd2, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0100, 8'd3, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0100, 8'd4, 2, 4'b0100, 8'd4);
        // mask widened, then narrowed to 1010 while channel 3 is in REQ
        add(0, 1, 0, 4'b1111, 8'd1, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd9, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd20, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd30, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd40, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd50, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd60, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd5, 3, 4'b1000, 8'd50);
        add(0, 1, 0, 4'b1010, 8'd70, 1, 4'b0010, 8'd70);
        // unanswered conversion, then windows prove the count held
        add(0, 1, 1, 4'b1010, 8'd0, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd3, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd100, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd1, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd1, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd1, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd1, 3, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b1010, 8'd1, 1, 4'b0010, 8'd3);
        add(0, 1, 0, 4'b1010, 8'd1, 3, 4'b1000, 8'd100);
        // reset mid-REQ, restart on lowest bit of 0110, drop enable in SETTLE
        add(1, 1, 0, 4'b0110, 8'd9, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0110, 8'd8, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0110, 8'd7, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0110, 8'd6, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0110, 8'd5, 1, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0110, 8'd4, 2, 4'b0000, 8'd0);
        add(0, 1, 0, 4'b0110, 8'd3, 1, 4'b0010, 8'd9);
        add(0, 0, 0, 4'b0110, 8'd77, 2, 4'b0100, 8'd77);

        abort = 1'b0;
        first = 1'b1;
        prev_ch = 0;
        for (int i = 0; i < tbl.size() && !abort; i++) begin
            v = tbl[i];
            if (v.start) begin
                do_reset(v.mask, v.en);
                first = 1'b1;
            end else begin
                enable = v.en;
            end
            wait_req(ok);
            if (!ok) begin
                chk("req_wait", 32'd0, 32'd1);
                abort = 1'b1;
            end else begin
                chk("sel", {30'd0, mux_sel}, v.ch);
                chk("busy", {31'd0, busy}, 32'd1);
                ch_mask = v.mask;
                if (v.to) begin
                    k = 1;
                    while (!err_timeout && k < 100) begin
                        @(negedge clk);
                        k++;
                    end
                    chk("to_cycle", k, 32'd20);
                    chk("to_req", {31'd0, conv_req}, 32'd0);
                    chk("to_r_valid", {28'd0, r_valid}, 32'd0);
                    @(negedge clk);
                    chk("to_pulse", {31'd0, err_timeout}, 32'd0);
                end else begin
                    repeat (2) @(negedge clk);
                    conv_done = 1'b1;
                    conv_data = v.d;
                    @(negedge clk);
                    conv_done = 1'b0;
                    conv_data = 8'h00;
                    chk("r_valid", {28'd0, r_valid}, {28'd0, v.vld});
                    if (v.vld != 4'b0000) exp_rv[v.ch] = v.val;
                    chk("r_val_s", r_val_s, model_rv());
                    chk("err_quiet", {31'd0, err_timeout}, 32'd0);
                    @(negedge clk);
                    chk("valid_pulse", {28'd0, r_valid}, 32'd0);
                end
                if (!first) chk("req_low_len", last_low, 32'd17);
                if (!first && prev_ch != v.ch)
                    chk("settle_len", last_since, 32'd16);
                first = 1'b0;
                prev_ch = v.ch;
            end
        end

        if (!abort) begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
            conv_done = 1'b1;
            conv_data = 8'hff;
            @(negedge clk);
            conv_done = 1'b0;
            conv_data = 8'h00;
            chk("idle_r_valid", {28'd0, r_valid}, 32'd0);
            chk("idle_req", {31'd0, conv_req}, 32'd0);
            chk("idle_r_val_s", r_val_s, model_rv());
            repeat (5) @(negedge clk);
            chk("idle_busy_late", {31'd0, busy}, 32'd0);
            chk("idle_req_late", {31'd0, conv_req}, 32'd0);
            chk("idle_mux", {30'd0, mux_sel}, 32'd2);
            chk("idle_r_val_late", r_val_s, model_rv());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ribbon_scan_sequencer.md
# ribbon_scan_sequencer

Scan controller sharing one 8-bit ribbon ADC between up to NUM_CH ribbon sensors. It steps the analog mux round-robin over the enabled channels and waits a settle time after each switch. It then runs a request/done conversion handshake with the ADC front end and keeps a windowed peak-hold per channel. The per-channel stabilized values go to the synth voice logic.

## Interface
- NUM_CH, 4: number of ribbon channels (2..8).
- WINDOW_SAMPLES, 64: conversions per channel per peak-hold window (≥2).
- SETTLE_CYCLES, 16: clk cycles held after a mux change before requesting a conversion (≥1).
- TIMEOUT, 1024: max clk cycles waiting for conv_done (≥2).

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  scan run/stop.
- ch_mask  in  NUM_CH  bit i = scan channel i.
- mux_sel  out  $clog2(NUM_CH)  analog mux select.
- conv_req  out  1  conversion request, level.
- conv_done  in  1  one-cycle pulse, conv_data valid.
- conv_data  in  8  ADC result.
- r_val_s  out  NUM_CH*8  stabilized values; channel i at [8i+7:8i].
- r_valid  out  NUM_CH  one-cycle pulse when channel i's r_val_s updates.
- err_timeout  out  1  one-cycle pulse on conversion timeout.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SETTLE, REQ, UPDATE.
- IDLE:
  - If enable=1 and ch_mask≠0, select the channel to scan: the lowest set bit after the last channel scanned, searching upward and wrapping to 0.
  - After reset, the search starts from the bit after NUM_CH-1, so the lowest set bit is chosen.
  - Load mux_sel with that channel and go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to REQ.
- REQ:
  - conv_req=1.
  - On conv_done=1, capture conv_data and go to UPDATE.
  - If TIMEOUT cycles elapse in REQ with no conv_done, pulse err_timeout, discard the sample (no count or max change) and go to the next-channel decision.
- UPDATE, for channel c with sample d:
  - If count[c]==WINDOW_SAMPLES-1: r_val_s[c] <= max(r_max[c], d); r_max[c] <= 0; count[c] <= 0; pulse r_valid[c].
  - Otherwise: r_max[c] <= max(r_max[c], d); count[c] <= count[c]+1.
  - Then make the next-channel decision.
- Next-channel decision:
  - If enable=1 and ch_mask≠0, pick the next set bit after c (wrapping) and go to SETTLE.
    - When the chosen channel equals mux_sel, SETTLE still runs in full.
  - Otherwise go to IDLE.
- Per-channel state: r_max and count. Comparisons are unsigned 8-bit. count width is $clog2(WINDOW_SAMPLES).
- A channel cleared from ch_mask keeps its r_val_s, r_max and count frozen and resumes from them when it is re-enabled.
- enable or ch_mask changes during SETTLE or REQ do not abort the step in progress. They take effect at the next-channel decision.
- conv_done outside REQ is ignored.

## Timing
- Reset (rst=0, asynchronous): state IDLE; mux_sel=0, conv_req=0, r_val_s=0, r_valid=0, err_timeout=0, busy=0; all r_max and count = 0.
- Reset asserted mid-conversion drops conv_req immediately.
- conv_req is registered:
  - It rises on the first REQ cycle, exactly SETTLE_CYCLES cycles after mux_sel changes.
  - It falls the cycle after conv_done is sampled.
- Sample to output: r_valid and the new r_val_s appear 1 cycle after the conv_done that completes the window (registered in UPDATE).
- Steady state per channel step: SETTLE_CYCLES + (cycles to conv_done) + 2 cycles.
- Timeout: err_timeout pulses on cycle TIMEOUT of REQ (first REQ cycle = 1), and conv_req drops that same cycle.
- r_valid and err_timeout are never high for more than one cycle.

## Test plan
- Reset, then enable=1, ch_mask=4'b1111, ADC model answering 3 cycles after conv_req:
  - mux_sel sequence is 0,1,2,3,0.
  - conv_req rises 16 cycles after each mux change.
- WINDOW_SAMPLES=4, channel 2 only (mask 4'b0100), samples 10,200,50,7:
  - r_valid[2] pulses once, r_val_s[2]=200.
  - The next window of 1,2,3,4 gives r_val_s[2]=4 (max cleared).
- ch_mask=4'b1010 while mux_sel=3 is in REQ:
  - The current conversion completes.
  - Next mux_sel=1, then 3; channels 0 and 2 are never selected and their values are unchanged.
- ADC never asserts conv_done, TIMEOUT=20:
  - err_timeout pulses on REQ cycle 20.
  - count is unchanged and the scan moves to the next channel.
- Assert rst=0 during REQ:
  - conv_req=0 and all r_val_s=0 without waiting for a clock edge.
  - After release, the first selected channel is the lowest set mask bit.
- enable drops during SETTLE:
  - The conversion still runs and UPDATE commits the sample.
  - Then the block goes IDLE with busy=0, and a later conv_done pulse is ignored.
